alt_ddr2_agx2_local_cmd_bridge: RTL and testbench

ALT_DDR2_AGX2_LOCAL_CMD_BRIDGE -- requirements
Module: alt_ddr2_agx2_local_cmd_bridge

---
 rtl/alt_ddr2_agx2_local_pkg.sv | 19 +
 rtl/alt_ddr2_agx2_rd_credit.sv | 41 ++++
 rtl/alt_ddr2_agx2_local_cmd_bridge.sv | 147 ++++++++++++++
 tb/tb_alt_ddr2_agx2_local_cmd_bridge.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alt_ddr2_agx2_local_pkg.sv
// Shared types and constants for the DDR2 local-interface command bridge.
package alt_ddr2_agx2_local_pkg;

  typedef enum logic [1:0] {StIdle, StRdReq, StWrFirst, StWrBurst} state_e;

  localparam int unsigned DefAddrW      = 25;
  localparam int unsigned DefDataW      = 256;
  localparam int unsigned DefBeW        = 32;
  localparam int unsigned DefMaxRdBeats = 16;
  localparam int unsigned CreditW       = 5;

  localparam logic [2:0] SizeMin = 3'd1;
  localparam logic [2:0] SizeMax = 3'd4;

  function automatic logic size_legal(logic [2:0] size);
    return (size >= SizeMin) && (size <= SizeMax);
  endfunction

endpackage

// File: rtl/alt_ddr2_agx2_rd_credit.sv
// Outstanding read-beat counter with saturation and unexpected-return detection.
module alt_ddr2_agx2_rd_credit
  import alt_ddr2_agx2_local_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               add_i,
  input  logic [2:0]         add_size_i,
  input  logic               ret_i,
  output logic [CreditW-1:0] credit_o,
  output logic               err_unexp_o
);

  logic [CreditW-1:0] credit_q, credit_d;
  logic               err_q, err_d;
  logic [CreditW:0]   sum;

  always_comb begin
    sum = {1'b0, credit_q} + (add_i ? {{(CreditW - 2){1'b0}}, add_size_i} : '0);
    // A return with nothing outstanding is flagged and never decrements.
    if (ret_i && (credit_q != '0)) begin
      sum = sum - (CreditW + 1)'(1);
    end
    credit_d = sum[CreditW] ? '1 : sum[CreditW-1:0];
    err_d    = err_q | (ret_i && (credit_q == '0));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      credit_q <= '0;
      err_q    <= 1'b0;
    end else begin
      credit_q <= credit_d;
      err_q    <= err_d;
    end
  end

  assign credit_o    = credit_q;
  assign err_unexp_o = err_q;

endmodule

// File: rtl/alt_ddr2_agx2_local_cmd_bridge.sv
// Bridges a valid/ready user command port onto the DDR2 controller local interface,
// with read-beat credit limiting and sticky error flags.
module alt_ddr2_agx2_local_cmd_bridge
  import alt_ddr2_agx2_local_pkg::*;
#(
  parameter int unsigned ADDR_W       = DefAddrW,
  parameter int unsigned DATA_W       = DefDataW,
  parameter int unsigned BE_W         = DefBeW,
  parameter int unsigned MAX_RD_BEATS = DefMaxRdBeats
) (
  input  logic               phy_clk,
  input  logic               reset_phy_clk_n,
  input  logic               usr_cmd_valid,
  output logic               usr_cmd_ready,
  input  logic               usr_cmd_write,
  input  logic [ADDR_W-1:0]  usr_cmd_addr,
  input  logic [2:0]         usr_cmd_size,
  input  logic               usr_wdata_valid,
  output logic               usr_wdata_ready,
  input  logic [DATA_W-1:0]  usr_wdata,
  input  logic [BE_W-1:0]    usr_be,
  output logic [DATA_W-1:0]  usr_rdata,
  output logic               usr_rdata_valid,
  input  logic               local_init_done,
  input  logic               local_ready,
  output logic [ADDR_W-1:0]  local_address,
  output logic [2:0]         local_size,
  output logic               local_burstbegin,
  output logic               local_read_req,
  output logic               local_write_req,
  output logic [DATA_W-1:0]  local_wdata,
  output logic [BE_W-1:0]    local_be,
  input  logic [DATA_W-1:0]  local_rdata,
  input  logic               local_rdata_valid,
  output logic [CreditW-1:0] rd_credit_used,
  output logic               err_bad_size,
  output logic               err_unexp_rdata
);

  localparam logic [CreditW:0] MaxRd = (CreditW + 1)'(MAX_RD_BEATS);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [2:0]          size_q, size_d;
  logic [2:0]          cnt_q, cnt_d;
  logic                err_bad_q, err_bad_d;
  logic [DATA_W-1:0]   rdata_q;
  logic                rvalid_q;
  logic                rd_accept;
  logic                cmd_fire;
  logic                credit_ok;
  logic [CreditW:0]    credit_need;

  always_comb begin
    state_d          = state_q;
    addr_d           = addr_q;
    size_d           = size_q;
    cnt_d            = cnt_q;
    err_bad_d        = err_bad_q;
    usr_cmd_ready    = 1'b0;
    usr_wdata_ready  = 1'b0;
    local_read_req   = 1'b0;
    local_write_req  = 1'b0;
    local_burstbegin = 1'b0;
    local_wdata      = '0;
    local_be         = '0;
    rd_accept        = 1'b0;
    cmd_fire         = 1'b0;
    credit_need      = {1'b0, rd_credit_used} + {{(CreditW - 2){1'b0}}, size_q};
    credit_ok        = (credit_need <= MaxRd);

    unique case (state_q)
      StIdle: begin
        // Gated by reset so the port reads 0 while reset is held.
        usr_cmd_ready = reset_phy_clk_n & local_init_done;
        cmd_fire      = usr_cmd_valid & usr_cmd_ready;
        if (cmd_fire) begin
          if (size_legal(usr_cmd_size)) begin
            addr_d  = usr_cmd_addr;
            size_d  = usr_cmd_size;
            cnt_d   = usr_cmd_size;
            state_d = usr_cmd_write ? StWrFirst : StRdReq;
          end else begin
            err_bad_d = 1'b1;
          end
        end
      end
      StRdReq: begin
        local_read_req   = credit_ok;
        local_burstbegin = credit_ok;
        rd_accept        = credit_ok & local_ready;
        if (rd_accept) begin
          state_d = StIdle;
        end
      end
      StWrFirst, StWrBurst: begin
        local_write_req  = usr_wdata_valid;
        usr_wdata_ready  = local_ready;
        local_wdata      = usr_wdata;
        local_be         = usr_be;
        local_burstbegin = (state_q == StWrFirst) & usr_wdata_valid;
        if (usr_wdata_valid && local_ready) begin
          cnt_d   = cnt_q - 3'd1;
          state_d = (cnt_q == 3'd1) ? StIdle : StWrBurst;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge phy_clk or negedge reset_phy_clk_n) begin
    if (!reset_phy_clk_n) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      size_q    <= '0;
      cnt_q     <= '0;
      err_bad_q <= 1'b0;
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      size_q    <= size_d;
      cnt_q     <= cnt_d;
      err_bad_q <= err_bad_d;
      rdata_q   <= local_rdata;
      rvalid_q  <= local_rdata_valid;
    end
  end

  alt_ddr2_agx2_rd_credit u_rd_credit (
    .clk_i       (phy_clk),
    .rst_ni      (reset_phy_clk_n),
    .add_i       (rd_accept),
    .add_size_i  (size_q),
    .ret_i       (local_rdata_valid),
    .credit_o    (rd_credit_used),
    .err_unexp_o (err_unexp_rdata)
  );

  assign local_address   = addr_q;
  assign local_size      = size_q;
  assign err_bad_size    = err_bad_q;
  assign usr_rdata       = rdata_q;
  assign usr_rdata_valid = rvalid_q;

endmodule

// File: tb/tb_alt_ddr2_agx2_local_cmd_bridge.sv
// Directed bench for the local command bridge with a transaction-level reference model.
module tb_alt_ddr2_agx2_local_cmd_bridge;

  localparam int AW   = 25;
  localparam int DW   = 256;
  localparam int BW   = 32;
  localparam int MAXB = 16;

  logic          phy_clk = 1'b0;
  logic          reset_phy_clk_n = 1'b1;
  logic          usr_cmd_valid = 1'b0;
  logic          usr_cmd_ready;
  logic          usr_cmd_write = 1'b0;
  logic [AW-1:0] usr_cmd_addr = '0;
  logic [2:0]    usr_cmd_size = '0;
  logic          usr_wdata_valid = 1'b0;
  logic          usr_wdata_ready;
  logic [DW-1:0] usr_wdata = '0;
  logic [BW-1:0] usr_be = '0;
  logic [DW-1:0] usr_rdata;
  logic          usr_rdata_valid;
  logic          local_init_done = 1'b0;
  logic          local_ready = 1'b0;
  logic [AW-1:0] local_address;
  logic [2:0]    local_size;
  logic          local_burstbegin;
  logic          local_read_req;
  logic          local_write_req;
  logic [DW-1:0] local_wdata;
  logic [BW-1:0] local_be;
  logic [DW-1:0] local_rdata = '0;
  logic          local_rdata_valid = 1'b0;
  logic [4:0]    rd_credit_used;
  logic          err_bad_size;
  logic          err_unexp_rdata;

  always #5 phy_clk = ~phy_clk;

  alt_ddr2_agx2_local_cmd_bridge #(
    .ADDR_W       (AW),
    .DATA_W       (DW),
    .BE_W         (BW),
    .MAX_RD_BEATS (MAXB)
  ) dut (
    .phy_clk           (phy_clk),
    .reset_phy_clk_n   (reset_phy_clk_n),
    .usr_cmd_valid     (usr_cmd_valid),
    .usr_cmd_ready     (usr_cmd_ready),
    .usr_cmd_write     (usr_cmd_write),
    .usr_cmd_addr      (usr_cmd_addr),
    .usr_cmd_size      (usr_cmd_size),
    .usr_wdata_valid   (usr_wdata_valid),
    .usr_wdata_ready   (usr_wdata_ready),
    .usr_wdata         (usr_wdata),
    .usr_be            (usr_be),
    .usr_rdata         (usr_rdata),
    .usr_rdata_valid   (usr_rdata_valid),
    .local_init_done   (local_init_done),
    .local_ready       (local_ready),
    .local_address     (local_address),
    .local_size        (local_size),
    .local_burstbegin  (local_burstbegin),
    .local_read_req    (local_read_req),
    .local_write_req   (local_write_req),
    .local_wdata       (local_wdata),
    .local_be          (local_be),
    .local_rdata       (local_rdata),
    .local_rdata_valid (local_rdata_valid),
    .rd_credit_used    (rd_credit_used),
    .err_bad_size      (err_bad_size),
    .err_unexp_rdata   (err_unexp_rdata)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one pending read or a count of write beats left, plus credit arithmetic.
  int            m_credit = 0;
  bit            m_err_unexp = 1'b0;
  bit            m_err_bad = 1'b0;
  bit            m_rd_pend = 1'b0;
  int            m_rd_size = 0;
  int            m_wr_left = 0;
  bit            m_wr_first = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [2:0]    m_size = '0;
  bit            m_rv = 1'b0;
  logic [DW-1:0] m_rd = '0;
  int            m_wr_acc = 0;

  always @(posedge phy_clk or negedge reset_phy_clk_n) begin : model
    int c;
    bit idle;
    if (!reset_phy_clk_n) begin
      m_credit <= 0; m_err_unexp <= 1'b0; m_err_bad <= 1'b0; m_rd_pend <= 1'b0;
      m_rd_size <= 0; m_wr_left <= 0; m_wr_first <= 1'b0; m_addr <= '0; m_size <= '0;
      m_rv <= 1'b0; m_rd <= '0;
    end else begin
      idle = !m_rd_pend && (m_wr_left == 0);
      c = m_credit;
      if (m_rd_pend && (m_credit + m_rd_size <= MAXB) && local_ready) begin
        c = c + m_rd_size;
        m_rd_pend <= 1'b0;
      end
      if (local_rdata_valid) begin
        if (m_credit == 0) m_err_unexp <= 1'b1;
        else c = c - 1;
      end
      m_credit <= c;
      if ((m_wr_left > 0) && usr_wdata_valid && local_ready) begin
        m_wr_left  <= m_wr_left - 1;
        m_wr_first <= 1'b0;
        m_wr_acc   <= m_wr_acc + 1;
      end
      if (idle && local_init_done && usr_cmd_valid) begin
        if (usr_cmd_size >= 3'd1 && usr_cmd_size <= 3'd4) begin
          m_addr <= usr_cmd_addr;
          m_size <= usr_cmd_size;
          if (usr_cmd_write) begin
            m_wr_left  <= int'(usr_cmd_size);
            m_wr_first <= 1'b1;
          end else begin
            m_rd_pend <= 1'b1;
            m_rd_size <= int'(usr_cmd_size);
          end
        end else begin
          m_err_bad <= 1'b1;
        end
      end
      m_rv <= local_rdata_valid;
      m_rd <= local_rdata;
    end
  end

  always @(negedge phy_clk) begin : compare
    bit rd_ok, wr_act, idle;
    if (chk_en) begin
      rd_ok  = reset_phy_clk_n && m_rd_pend && (m_credit + m_rd_size <= MAXB);
      wr_act = reset_phy_clk_n && (m_wr_left > 0);
      idle   = !m_rd_pend && (m_wr_left == 0);
      check("cmd_ready", usr_cmd_ready, reset_phy_clk_n && idle && local_init_done);
      check("read_req", local_read_req, rd_ok);
      check("write_req", local_write_req, wr_act && usr_wdata_valid);
      check("burstbegin", local_burstbegin, rd_ok || (wr_act && m_wr_first && usr_wdata_valid));
      check("wdata_ready", usr_wdata_ready, wr_act && local_ready);
      check("local_wdata", local_wdata, wr_act ? usr_wdata : '0);
      check("local_be", local_be, wr_act ? usr_be : '0);
      check("address", local_address, m_addr);
      check("size", local_size, m_size);
      check("credit", rd_credit_used, m_credit);
      check("err_bad_size", err_bad_size, m_err_bad);
      check("err_unexp", err_unexp_rdata, m_err_unexp);
      check("usr_rdata_valid", usr_rdata_valid, m_rv);
      check("usr_rdata", usr_rdata, m_rd);
    end
  end

  task automatic tick();
    @(posedge phy_clk);
    #1;
  endtask

  // Presents a command and returns #1 after the cycle in which it was taken.
  task automatic send_cmd(input bit wr, input logic [AW-1:0] a, input logic [2:0] s);
    int k;
    usr_cmd_valid = 1'b1;
    usr_cmd_write = wr;
    usr_cmd_addr  = a;
    usr_cmd_size  = s;
    k = 0;
    while (!usr_cmd_ready && k < 50) begin
      tick();
      k++;
    end
    if (k == 50) check("cmd_handshake_timeout", 1'b0, 1'b1);
    tick();
    usr_cmd_valid = 1'b0;
  endtask

  initial begin
    static bit rdy_pat[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    int beats;
    int acc0;

    #1 reset_phy_clk_n = 1'b0;
    chk_en = 1'b1;
    tick(); tick();
    local_init_done = 1'b1;
    local_ready     = 1'b1;
    reset_phy_clk_n = 1'b1;
    tick();
    check("lit_reset_credit", rd_credit_used, 5'd0);
    check("lit_reset_cmd_ready", usr_cmd_ready, 1'b1);

    // Read of 4 beats at 0x100.
    send_cmd(1'b0, 25'h100, 3'd4);
    check("lit_rd_req", local_read_req, 1'b1);
    check("lit_rd_bb", local_burstbegin, 1'b1);
    check("lit_rd_addr", local_address, 25'h100);
    tick();
    check("lit_rd_req_once", local_read_req, 1'b0);
    check("lit_rd_credit4", rd_credit_used, 5'd4);
    for (int i = 0; i < 4; i++) begin
      local_rdata_valid = 1'b1;
      local_rdata = DW'(32'hC0DE_0000 + i);
      tick();
      check("lit_rdata_valid", usr_rdata_valid, 1'b1);
      check("lit_rdata", usr_rdata, DW'(32'hC0DE_0000 + i));
    end
    local_rdata_valid = 1'b0;
    tick();
    check("lit_rdata_valid_off", usr_rdata_valid, 1'b0);
    check("lit_rd_credit0", rd_credit_used, 5'd0);

    // Write of 3 beats with local_ready 1,0,1,1; init_done dropped mid-burst.
    send_cmd(1'b1, 25'h2A0, 3'd3);
    acc0  = m_wr_acc;
    beats = 0;
    usr_wdata_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      local_ready     = rdy_pat[i];
      local_init_done = (i != 1);
      usr_wdata = {8{32'hBEEF_0000 + 32'(beats)}};
      usr_be    = 32'hFFFF_0000 | 32'(beats);
      #1;
      check("lit_wr_bb", local_burstbegin, (i == 0));
      check("lit_wr_addr", local_address, 25'h2A0);
      if (local_write_req && local_ready) beats++;
      tick();
    end
    usr_wdata_valid = 1'b0;
    local_ready     = 1'b1;
    check("lit_wr_beats", beats, 3);
    check("model_wr_beats", m_wr_acc - acc0, 3);
    check("lit_wr_idle", usr_cmd_ready, 1'b1);

    // Credit exhaustion: four 4-beat reads fill the credit, a fifth waits.
    for (int i = 0; i < 4; i++) begin
      send_cmd(1'b0, AW'(32'h400 + 32'(i) * 32'h10), 3'd4);
      tick();
    end
    check("lit_credit16", rd_credit_used, 5'd16);
    send_cmd(1'b0, 25'h500, 3'd1);
    check("lit_rd5_held", local_read_req, 1'b0);
    tick(); tick();
    check("lit_rd5_still_held", local_read_req, 1'b0);
    local_rdata_valid = 1'b1;
    local_rdata = DW'(32'h55);
    tick();
    local_rdata_valid = 1'b0;
    check("lit_rd5_issued", local_read_req, 1'b1);
    tick();
    check("lit_credit_after5", rd_credit_used, 5'd16);
    local_rdata_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      local_rdata = DW'(i);
      tick();
    end
    local_rdata_valid = 1'b0;
    tick();
    check("lit_credit_drained", rd_credit_used, 5'd0);

    // Illegal sizes are consumed and flagged.
    check("lit_bad_clear", err_bad_size, 1'b0);
    send_cmd(1'b0, 25'h10, 3'd0);
    check("lit_bad0_noreq", local_read_req, 1'b0);
    check("lit_bad0_flag", err_bad_size, 1'b1);
    send_cmd(1'b1, 25'h20, 3'd7);
    check("lit_bad7_noreq", local_write_req, 1'b0);
    check("lit_bad7_idle", usr_cmd_ready, 1'b1);

    // Unexpected return, then a read acceptance netted with a return.
    check("lit_unexp_clear", err_unexp_rdata, 1'b0);
    local_rdata_valid = 1'b1;
    tick();
    local_rdata_valid = 1'b0;
    check("lit_unexp_flag", err_unexp_rdata, 1'b1);
    check("lit_unexp_credit", rd_credit_used, 5'd0);
    send_cmd(1'b0, 25'h600, 3'd4);
    tick();
    send_cmd(1'b0, 25'h640, 3'd3);
    local_rdata_valid = 1'b1;
    tick();
    local_rdata_valid = 1'b0;
    check("lit_net_credit", rd_credit_used, 5'd6);
    local_rdata_valid = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    local_rdata_valid = 1'b0;
    tick();

    // Reset in the middle of a 4-beat write.
    send_cmd(1'b1, 25'h700, 3'd4);
    usr_wdata_valid = 1'b1;
    usr_wdata = {8{32'h1234_5678}};
    usr_be = 32'hFFFF_FFFF;
    tick();
    #2 reset_phy_clk_n = 1'b0;
    #1;
    check("lit_rst_write_req", local_write_req, 1'b0);
    check("lit_rst_cmd_ready", usr_cmd_ready, 1'b0);
    check("lit_rst_addr", local_address, 25'h0);
    check("lit_rst_wdata", local_wdata, '0);
    check("lit_rst_err", {err_bad_size, err_unexp_rdata}, 2'b00);
    tick(); tick();
    local_init_done = 1'b0;
    reset_phy_clk_n = 1'b1;
    tick();
    check("lit_post_rst_no_init", usr_cmd_ready, 1'b0);
    check("lit_post_rst_abandon", local_write_req, 1'b0);
    local_init_done = 1'b1;
    #1;
    check("lit_post_rst_ready", usr_cmd_ready, 1'b1);
    usr_wdata_valid = 1'b0;
    tick(); tick();

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
